// File: rtl/eep_pkg.sv
// EEPROM responder shared types and defaults.
// State encoding and word geometry used by eep_resp and its timer.
package eep_pkg;

  localparam int EEP_DATA_W  = 14;
  localparam int EEP_ADDR_W  = 2;
  localparam int EEP_PGM_CYC = 1500;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PUMP,
    COMMIT
  } eep_state_e;

endpackage

// File: rtl/eep_pgm_timer.sv
// Saturating enable-gated programming-interval counter.
// start loads 1, en increments, clr zeroes; tc flags MAX reached.
module eep_pgm_timer #(
  parameter int MAX = 1500,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic start_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i:   cnt_d = '0;
      start_i: cnt_d = W'(1);
      en_i:    if (cnt_q != W'(MAX)) cnt_d = cnt_q + 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/eep_resp.sv
// Behavioural EEPROM responder: 4 non-volatile words, reads in one cycle,
// writes commit only after the charge pump is held for PGM_CYC cycles.
module eep_resp
  import eep_pkg::*;
#(
  parameter int                DATA_W  = EEP_DATA_W,
  parameter int                ADDR_W  = EEP_ADDR_W,
  parameter int                PGM_CYC = EEP_PGM_CYC,
  parameter logic [DATA_W-1:0] INIT0   = '0,
  parameter logic [DATA_W-1:0] INIT1   = '0,
  parameter logic [DATA_W-1:0] INIT2   = '0,
  parameter logic [DATA_W-1:0] INIT3   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eep_cs_n,
  input  logic              eep_r_w_n,
  input  logic [ADDR_W-1:0] eep_addr,
  input  logic [DATA_W-1:0] eep_wr_data,
  input  logic              chrg_pmp_en,
  output logic [DATA_W-1:0] eep_rd_data,
  output logic              busy,
  output logic              wr_done,
  output logic              pgm_err
);

  localparam int NW = 1 << ADDR_W;

  typedef logic [NW-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < NW; i++) begin
      case (i)
        0:       m[i] = INIT0;
        1:       m[i] = INIT1;
        2:       m[i] = INIT2;
        3:       m[i] = INIT3;
        default: m[i] = '0;
      endcase
    end
    return m;
  endfunction

  // Non-volatile: preloaded once, never touched by rst.
  mem_t mem_q = init_mem();

  eep_state_e        state_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [DATA_W-1:0] rd_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic rd_req;
  logic wr_req;
  logic tmr_start;
  logic tmr_en;
  logic tmr_clr;
  logic tmr_tc;

  assign rd_req = !eep_cs_n && eep_r_w_n;
  assign wr_req = !eep_cs_n && !eep_r_w_n;

  assign tmr_start = (state_q == ARMED) && chrg_pmp_en;
  assign tmr_en    = (state_q == PUMP) && chrg_pmp_en;
  assign tmr_clr   = !(tmr_start || tmr_en);

  eep_pgm_timer #(
    .MAX (PGM_CYC)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (tmr_clr),
    .start_i (tmr_start),
    .en_i    (tmr_en),
    .tc_o    (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      rd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rd_req) rd_q <= mem_q[eep_addr];
      if (wr_req) begin
        if (state_q == IDLE) begin
          pend_addr_q <= eep_addr;
          pend_data_q <= eep_wr_data;
          err_q       <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (wr_req) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
          end
        end
        ARMED: begin
          if (chrg_pmp_en) state_q <= PUMP;
        end
        PUMP: begin
          if (!chrg_pmp_en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (tmr_tc) begin
            state_q <= COMMIT;
            done_q  <= 1'b1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Same-edge reads still see the old word.
  always_ff @(posedge clk) begin
    if (state_q == COMMIT) mem_q[pend_addr_q] <= pend_data_q;
  end

  assign eep_rd_data = rd_q;
  assign busy        = busy_q;
  assign wr_done     = done_q;
  assign pgm_err     = err_q;

endmodule

// File: tb/tb_eep_resp.sv
// Directed self-checking bench for eep_resp with a read scoreboard.
module tb_eep_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        eep_cs_n;
  logic        eep_r_w_n;
  logic [1:0]  eep_addr;
  logic [13:0] eep_wr_data;
  logic        chrg_pmp_en;
  logic [13:0] eep_rd_data;
  logic        busy;
  logic        wr_done;
  logic        pgm_err;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  logic [13:0] sb[$];

  eep_resp #(
    .PGM_CYC (8),
    .INIT0   (14'h0001),
    .INIT1   (14'h0002),
    .INIT2   (14'h0003),
    .INIT3   (14'h0004)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .eep_cs_n    (eep_cs_n),
    .eep_r_w_n   (eep_r_w_n),
    .eep_addr    (eep_addr),
    .eep_wr_data (eep_wr_data),
    .chrg_pmp_en (chrg_pmp_en),
    .eep_rd_data (eep_rd_data),
    .busy        (busy),
    .wr_done     (wr_done),
    .pgm_err     (pgm_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_issue(input logic [1:0] a, input logic [13:0] e);
    eep_cs_n  = 1'b0;
    eep_r_w_n = 1'b1;
    eep_addr  = a;
    sb.push_back(e);
  endtask

  task automatic rd_check(input string tag);
    eep_cs_n = 1'b1;
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else chk(tag, eep_rd_data, sb.pop_front());
  endtask

  task automatic rd(input logic [1:0] a, input logic [13:0] e);
    rd_issue(a, e);
    tick();
    rd_check($sformatf("rd_addr%0d", a));
  endtask

  task automatic wr(input logic [1:0] a, input logic [13:0] d);
    eep_cs_n    = 1'b0;
    eep_r_w_n   = 1'b0;
    eep_addr    = a;
    eep_wr_data = d;
    tick();
    eep_cs_n  = 1'b1;
    eep_r_w_n = 1'b1;
  endtask

  // Holds the pump until wr_done (bounded); returns edges counted.
  task automatic pump_to_done(output int n, input int rd_at,
                              input logic [1:0] ra, input logic [13:0] re);
    bit iss;
    n = 0;
    chrg_pmp_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      iss = 0;
      if (i == rd_at) begin
        rd_issue(ra, re);
        iss = 1;
      end
      tick();
      n = i;
      if (iss) rd_check("rd_during_pump");
      if (wr_done) break;
    end
  endtask

  initial begin
    int n;
    bit any_done;
    rst = 1'b1;
    eep_cs_n = 1'b1;
    eep_r_w_n = 1'b1;
    eep_addr = '0;
    eep_wr_data = '0;
    chrg_pmp_en = 1'b0;
    repeat (3) tick();
    chk("rst_rd_data", eep_rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_pgm_err", pgm_err, 0);
    rst = 1'b0;
    tick();

    rd(0, 14'h0001);
    rd(1, 14'h0002);
    rd(2, 14'h0003);
    rd(3, 14'h0004);
    tick();
    chk("hold_rd_data", eep_rd_data, 14'h0004);
    chk("idle_busy", busy, 0);
    chk("idle_err", pgm_err, 0);

    wr(2, 14'h2ABC);
    chk("armed_busy", busy, 1);
    pump_to_done(n, 3, 2, 14'h0003);
    chk("commit_edges", n, 9);
    chk("commit_pulse", wr_done, 1);
    rd_issue(2, 14'h0003);
    tick();
    rd_check("rd_commit_cycle");
    chk("done_once", wr_done, 0);
    chk("busy_fall", busy, 0);
    chrg_pmp_en = 1'b0;
    rd(2, 14'h2ABC);

    wr(1, 14'h0155);
    chrg_pmp_en = 1'b1;
    any_done = 0;
    repeat (5) begin
      tick();
      any_done |= wr_done;
    end
    chrg_pmp_en = 1'b0;
    tick();
    any_done |= wr_done;
    chk("abort_err", pgm_err, 1);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", any_done, 0);
    rd(1, 14'h0002);

    wr(0, 14'h1111);
    chk("wr_clears_err", pgm_err, 0);
    tick();
    wr(3, 14'h3333);
    chk("armed_wr_err", pgm_err, 1);
    pump_to_done(n, 0, 0, 14'h0000);
    chk("commit2_edges", n, 9);
    chrg_pmp_en = 1'b0;
    tick();
    rd(0, 14'h1111);
    rd(3, 14'h0004);

    wr(3, 14'h0777);
    chrg_pmp_en = 1'b1;
    repeat (4) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_data", eep_rd_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", wr_done, 0);
    chk("mid_rst_err", pgm_err, 0);
    tick();
    rst = 1'b0;
    chrg_pmp_en = 1'b0;
    tick();
    rd(3, 14'h0004);

    any_done = 0;
    for (int i = 0; i < 20; i++) begin
      chrg_pmp_en = ~chrg_pmp_en;
      tick();
      any_done |= (busy | wr_done);
    end
    chrg_pmp_en = 1'b0;
    chk("idle_toggle_quiet", any_done, 0);
    rd(0, 14'h1111);
    rd(1, 14'h0002);
    rd(2, 14'h2ABC);
    rd(3, 14'h0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
